// File: rtl/traffic_phase_scheduler_if.sv
// Bus between the traffic phase scheduler and the junction environment.
// Handshake semantics: there is no valid/ready pair. req is a level that the
// scheduler samples on every rising clk edge (a one-cycle pulse is enough to
// register demand); every output is registered and valid in every cycle
// after reset. dbg_state exposes the scheduler FSM (0=ALLRED 1=GREEN 2=YELLOW).
// Optional macro EMERG_PREEMPT_EN adds the emerg / emerg_phase inputs.
interface traffic_phase_scheduler_if;
  logic [3:0] req;
  logic [2:0] light_M1;
  logic [2:0] light_M2;
  logic [2:0] light_MT;
  logic [2:0] light_S;
  logic       walk;
  logic [1:0] phase_id;
  logic [3:0] pending;
  logic [1:0] dbg_state;
`ifdef EMERG_PREEMPT_EN
  logic       emerg;
  logic [1:0] emerg_phase;
`endif

  // Environment side: drives demand, observes lamps
  modport master (
`ifdef EMERG_PREEMPT_EN
    output emerg, emerg_phase,
`endif
    output req,
    input  light_M1, light_M2, light_MT, light_S, walk, phase_id, pending, dbg_state
  );

  // Scheduler side
  modport slave (
`ifdef EMERG_PREEMPT_EN
    input  emerg, emerg_phase,
`endif
    input  req,
    output light_M1, light_M2, light_MT, light_S, walk, phase_id, pending, dbg_state
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Actuated phase scheduler: latches phase demand, serves it round-robin and
// sequences GREEN -> YELLOW -> ALLRED with min/max green and clearance times.
// Phases: P0 main through (M1+M2), P1 main turn (M1+MT), P2 side (S),
// P3 pedestrian (walk). Lamps are {red,yellow,green} one-hot, registered.
// Optional macro EMERG_PREEMPT_EN enables emergency preemption.
module traffic_phase_scheduler #(
  parameter int MIN_GREEN = 7,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int CNT_W     = 8
) (
  input logic                     clk,
  input logic                     rst,
  traffic_phase_scheduler_if.slave bus
);
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_T - 1);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       phase_q, phase_d;
  logic [3:0]       pending_q, pending_d;
  logic             boot_q, boot_d;
  logic [2:0]       m1_q, m1_d, m2_q, m2_d, mt_q, mt_d, s_q, s_d;
  logic             walk_q, walk_d;
  logic [2:0]       lamp;

  logic [3:0] phase_mask;
  logic [3:0] others;
  logic [1:0] rr_sel;
  logic       min_ok;
  logic       hold_green;
  logic       preempt;
  logic       force_sel;
  logic [1:0] force_phase;

  // Closest pending phase after 'last' (wrapping, 'last' itself tried last);
  // returns 0 when nothing is pending.
  function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] last);
    logic [1:0] cand;
    rr_pick = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (pend[cand]) rr_pick = cand;
    end
  endfunction

`ifdef EMERG_PREEMPT_EN
  logic       emerg_prev_q;
  logic       emerg_rise;
  logic       emerg_pend_q, emerg_pend_d;
  logic [1:0] emerg_ph_q, emerg_ph_d;
  logic       emerg_held_q, emerg_held_d;
`endif

  // Arbitration and exit qualifiers shared by the FSM
  always_comb begin
    phase_mask = 4'b0001 << phase_q;
    others     = pending_q & ~phase_mask;
    rr_sel     = rr_pick(pending_q, phase_q);
`ifdef EMERG_PREEMPT_EN
    emerg_rise  = bus.emerg & ~emerg_prev_q;
    hold_green  = bus.emerg & (bus.emerg_phase == phase_q);
    preempt     = emerg_rise & (bus.emerg_phase != phase_q);
    // A green held by an emergency counts as having served its minimum
    min_ok      = (timer_q >= MIN_LAST) | emerg_held_q;
    force_sel   = emerg_pend_q | emerg_rise;
    force_phase = emerg_pend_q ? emerg_ph_q : bus.emerg_phase;
`else
    hold_green  = 1'b0;
    preempt     = 1'b0;
    min_ok      = (timer_q >= MIN_LAST);
    force_sel   = 1'b0;
    force_phase = 2'd0;
`endif
  end

  // FSM next state, phase timer, demand latching
  always_comb begin
    state_d   = state_q;
    timer_d   = (&timer_q) ? timer_q : timer_q + 1'b1;
    phase_d   = phase_q;
    boot_d    = boot_q;
    pending_d = pending_q | bus.req;
    unique case (state_q)
      ST_ALLRED: begin
        if (timer_q >= AR_LAST) begin
          state_d = ST_GREEN;
          timer_d = '0;
          boot_d  = 1'b0;
          phase_d = force_sel ? force_phase : (boot_q ? 2'd0 : rr_sel);
        end
      end
      ST_GREEN: begin
        // The phase being served cannot re-request itself
        pending_d = pending_q | (bus.req & ~phase_mask);
        if (preempt) begin
          state_d = ST_YELLOW;
          timer_d = '0;
        end else if (!hold_green && (others != 4'b0000)) begin
          // >= on max-out so a green that idled past MAX_GREEN still yields
          if ((min_ok && !bus.req[phase_q]) || (timer_q >= MAX_LAST)) begin
            state_d = ST_YELLOW;
            timer_d = '0;
          end
        end
      end
      ST_YELLOW: begin
        if (timer_q >= YEL_LAST) begin
          state_d = ST_ALLRED;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_ALLRED;
        timer_d = '0;
      end
    endcase
    // Served phase clears on green entry, overriding a same-cycle request
    if ((state_d == ST_GREEN) && (state_q != ST_GREEN)) pending_d[phase_d] = 1'b0;
  end

  // Lamp decode from the next state so the lamp bus is a plain register
  always_comb begin
    m1_d   = LAMP_R;
    m2_d   = LAMP_R;
    mt_d   = LAMP_R;
    s_d    = LAMP_R;
    walk_d = 1'b0;
    lamp   = (state_d == ST_GREEN) ? LAMP_G : LAMP_Y;
    if (state_d != ST_ALLRED) begin
      case (phase_d)
        2'd0: begin m1_d = lamp; m2_d = lamp; end
        2'd1: begin m1_d = lamp; mt_d = lamp; end
        2'd2: s_d = lamp;
        default: walk_d = (state_d == ST_GREEN);
      endcase
    end
  end

  // State, timer, phase and demand registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_ALLRED;
      timer_q   <= '0;
      phase_q   <= 2'd0;
      pending_q <= 4'b0000;
      boot_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
      boot_q    <= boot_d;
    end
  end

  // Lamp output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m1_q   <= LAMP_R;
      m2_q   <= LAMP_R;
      mt_q   <= LAMP_R;
      s_q    <= LAMP_R;
      walk_q <= 1'b0;
    end else begin
      m1_q   <= m1_d;
      m2_q   <= m2_d;
      mt_q   <= mt_d;
      s_q    <= s_d;
      walk_q <= walk_d;
    end
  end

`ifdef EMERG_PREEMPT_EN
  // Emergency request latch and held-green flag
  always_comb begin
    emerg_pend_d = emerg_pend_q;
    emerg_ph_d   = emerg_ph_q;
    emerg_held_d = emerg_held_q;
    if (emerg_rise && !((state_q == ST_GREEN) && (bus.emerg_phase == phase_q))) begin
      emerg_pend_d = 1'b1;
      emerg_ph_d   = bus.emerg_phase;
    end
    if ((state_q == ST_ALLRED) && (state_d == ST_GREEN)) begin
      emerg_pend_d = 1'b0;
      emerg_held_d = 1'b0;
    end else if ((state_q == ST_GREEN) && hold_green) begin
      emerg_held_d = 1'b1;
    end
  end

  // Emergency registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      emerg_prev_q <= 1'b0;
      emerg_pend_q <= 1'b0;
      emerg_ph_q   <= 2'd0;
      emerg_held_q <= 1'b0;
    end else begin
      emerg_prev_q <= bus.emerg;
      emerg_pend_q <= emerg_pend_d;
      emerg_ph_q   <= emerg_ph_d;
      emerg_held_q <= emerg_held_d;
    end
  end
`endif

  assign bus.light_M1  = m1_q;
  assign bus.light_M2  = m2_q;
  assign bus.light_MT  = mt_q;
  assign bus.light_S   = s_q;
  assign bus.walk      = walk_q;
  assign bus.phase_id  = phase_q;
  assign bus.pending   = pending_q;
  assign bus.dbg_state = state_q;
endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Actuated phase scheduler for the four-approach junction (main M1/M2, main turn MT, side S), with a pedestrian phase. Latches sensor requests and arbitrates round-robin between them. Enforces minimum/maximum green, yellow and all-red clearance, and drives the 3-bit lamp buses directly. Replaces the fixed-cycle sequencing in the traffic light controller with demand-driven sequencing.

Parameters:
MIN_GREEN, 7, minimum green duration in clk cycles (>=1)
MAX_GREEN, 20, maximum green duration when competing demand exists (>=MIN_GREEN)
YELLOW_T, 3, yellow duration in cycles (>=1)
ALLRED_T, 2, all-red clearance duration in cycles (>=1)
CNT_W, 8, phase timer width; must hold MAX_GREEN

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req  in  4  phase demand: [0] P0 main through, [1] P1 main turn, [2] P2 side, [3] P3 pedestrian
light_M1  out  3  lamp {red,yellow,green}, one-hot
light_M2  out  3  same encoding
light_MT  out  3  same encoding
light_S   out  3  same encoding
walk      out  1  pedestrian walk lamp
phase_id  out  2  phase currently owning green/yellow (last served during ALLRED)
pending   out  4  latched outstanding requests

Behaviour:
- Lamp encoding: red=3'b100, yellow=3'b010, green=3'b001.
- Phase map (GREEN state):
  - P0: M1 and M2 green.
  - P1: M1 and MT green.
  - P2: S green.
  - P3: all vehicle lamps red, walk=1.
  - Lamps not listed for the phase are red.
- States: ALLRED, GREEN, YELLOW. Timer clears on every state entry and increments each cycle.
- Reset (rst=0):
  - state=ALLRED, timer=0, phase_id=0, pending=0.
  - All lamps 3'b100, walk=0.
- ALLRED:
  - All lamps red, walk=0.
  - Lasts exactly ALLRED_T cycles, then GREEN of the selected next phase.
  - After reset, next phase is P0.
- Next-phase selection, at ALLRED exit: round-robin over pending, searching from phase_id+1 upward with wrap. If pending==0, select P0.
- GREEN:
  - On entry, pending[phase] clears.
  - While in GREEN, req[phase] does not set pending[phase]. Other req bits set their pending bits; these are sticky until served.
  - "Others" = pending excluding the current phase.
  - Exit to YELLOW at the end of the cycle in which timer>=MIN_GREEN-1, others!=0 and req[phase]==0 (gap-out).
  - Also exit when timer==MAX_GREEN-1 and others!=0 (max-out).
  - With others==0, GREEN holds indefinitely. Timer saturates at its max value.
- YELLOW:
  - Lamps that were green show 3'b010; the rest stay red; walk=0.
  - Lasts exactly YELLOW_T cycles, then ALLRED.
- Same-cycle req and pending-clear on green entry: clear wins for the served phase; set wins for all others.
- Reset asserted mid-operation: immediate all-red, state ALLRED, pending cleared.
- All outputs are registered. No combinational path from req to the lamps.

Optional Feature:
EMERG_PREEMPT_EN
- Defined: adds ports emerg (in, 1) and emerg_phase (in, 2).
  - emerg rising, while in GREEN of another phase: go to YELLOW next cycle, ignoring MIN_GREEN; then ALLRED; then GREEN of emerg_phase, overriding round-robin.
  - emerg rising during YELLOW or ALLRED: the sequence completes normally, then emerg_phase is selected.
  - emerg rising while already in GREEN of emerg_phase: no change.
  - GREEN is held while emerg=1, with no max-out.
  - After emerg falls, normal rules resume with timer treated as >=MIN_GREEN.
  - pending keeps latching throughout.
- Not defined: no extra ports; behaviour exactly as above.

Test Plan:
1. rst=0 for 3 cycles, then release -> all lamps 3'b100 and walk=0 during reset and 2 cycles after; light_M1=light_M2=3'b001 and phase_id=0 on the 3rd cycle after release.
2. No requests for 100 cycles after P0 green -> P0 stays green; pending=4'b0000.
3. 1-cycle pulse on req[2] in P0 green cycle 0 -> P0 green 7 cycles, M1/M2 yellow 3 cycles, all-red 2 cycles, then light_S=3'b001, phase_id=2, pending[2]=0.
4. In P2 green: req[2] held high, req[0] pulsed at green cycle 0 -> S stays green for exactly 20 cycles (max-out), then yellow.
5. In P2 green: req[0], req[1], req[3] pulsed simultaneously -> service order P3 (walk=1, all vehicle lamps red), then P0, then P1; each phase's pending bit clears on its green entry.
6. EMERG_PREEMPT_EN: in P0 green cycle 2, emerg=1 with emerg_phase=2 -> yellow on next cycle, 3 yellow + 2 all-red cycles, S green held while emerg=1 beyond 20 cycles.
